// File: rtl/m_mem_pkg.sv
// Shared definitions for the memory-stage responder.
//   SIZE_*      access size encodings carried on req_size
//   EXC_*       CP0 exception codes for address faults
//   state_t     responder FSM encoding (also exposed on dbg_state)
//   lane_mask() byte-lane write enables for a given size and address low bits
package m_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DM_RSP    = 3'd1,
    ST_DEV_WAIT  = 3'd2,
    ST_DEV_RSP   = 3'd3,
    ST_DEV_DRAIN = 3'd4
  } state_t;

  // size is expected to be normalised (3 already folded into SIZE_WORD)
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << lo;
      SIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/m_dm_ram.sv
// Data RAM: DM_WORDS x 32 synchronous RAM with per-byte write enables.
//   clk    clock
//   re     read enable; rdata updates on the next edge when high
//   be     byte write enables (bit i writes lane i)
//   idx    word index
//   wdata  write data, already replicated onto the enabled lanes
//   rdata  registered read data
module m_dm_ram #(
  parameter int DM_WORDS = 3072,
  parameter int IW       = 12
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DM_WORDS];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/m_mem_responder.sv
// Memory-stage load/store responder. Services each M-stage access from the
// internal data RAM or a memory-mapped device window, returns extended load
// data or a store ack, or raises an address exception towards CP0.
// Optional feature macro: MEM_ADDR_EXC_EN (address fault detection). When it
// is undefined, misaligned addresses are force-aligned, unmapped loads return
// 0, unmapped stores are acked without a write, sub-word device accesses are
// issued as words, and the exception outputs stay 0.
//
// Handshake: a request is taken on any edge where req_ready & req_valid &
// !flush; req_ready is high only in IDLE and DM_RSP, and a low req_ready
// means the caller must hold the request stable (the pipeline stalls).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   flush                         CP0 flush; blocks accept, kills DM_RSP output
//   req_*                         access request from the EX->M register
//   req_ready                     accept indication (see handshake above)
//   rsp_valid / rsp_rdata         one-cycle response, extended load data
//   exc_valid/exc_code/exc_pc/exc_badvaddr  one-cycle address exception
//   dev_req/dev_we/dev_addr/dev_wdata       device request, held until dev_ack
//   dev_ack / dev_rdata           device completion and read data
//   dbg_state                     current FSM state (m_mem_pkg::state_t)
module m_mem_responder
  import m_mem_pkg::*;
#(
  parameter int          DM_WORDS = 3072,
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV_SPAN = 32'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_badvaddr,
  output logic        dev_req,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata,
  output logic [2:0]  dbg_state
);

  localparam int          AW       = $clog2(4 * DM_WORDS);
  localparam int          IW       = AW - 2;
  localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

  state_t      state;
  logic        rsp_q, exc_q, ld_q, sign_q;
  logic [1:0]  lo_q, size_q;
  logic [31:0] dev_rdata_q, ram_rdata, ram_wdata, eff_addr, ld_data;
  logic [1:0]  size_n;
  logic        dm_hit, dev_hit, fault, accept, kill, ram_re;
  logic [3:0]  ram_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_ready = (state == ST_IDLE) || (state == ST_DM_RSP);
  assign accept    = req_ready & req_valid & ~flush;
  // A flush in DM_RSP only hides the response; a DM store already landed.
  assign kill      = flush & (state == ST_DM_RSP);
  assign dbg_state = state;

  // Request decode, evaluated on the cycle the request is presented.
  always_comb begin
    size_n   = (req_size == 2'd3) ? SIZE_WORD : req_size;
    eff_addr = req_addr;
`ifdef MEM_ADDR_EXC_EN
    dm_hit  = req_addr < DM_BYTES;
    dev_hit = (req_addr >= DEV_BASE) && ((req_addr - DEV_BASE) < DEV_SPAN);
    fault   = ((size_n == SIZE_HALF) && req_addr[0])
            | ((size_n == SIZE_WORD) && (req_addr[1:0] != 2'b00))
            | ~(dm_hit | dev_hit)
            | (dev_hit && (size_n != SIZE_WORD));
`else
    if (size_n == SIZE_HALF)      eff_addr[0]   = 1'b0;
    else if (size_n == SIZE_WORD) eff_addr[1:0] = 2'b00;
    dm_hit  = eff_addr < DM_BYTES;
    dev_hit = (eff_addr >= DEV_BASE) && ((eff_addr - DEV_BASE) < DEV_SPAN);
    fault   = 1'b0;
`endif
    case (size_n)
      SIZE_BYTE: ram_wdata = {4{req_wdata[7:0]}};
      SIZE_HALF: ram_wdata = {2{req_wdata[15:0]}};
      default:   ram_wdata = req_wdata;
    endcase
    ram_re = accept & dm_hit & ~fault & ~req_we;
    ram_be = (accept & dm_hit & ~fault & req_we) ? lane_mask(size_n, eff_addr[1:0]) : 4'b0000;
  end

  m_dm_ram #(.DM_WORDS(DM_WORDS), .IW(IW)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .be    (ram_be),
    .idx   (eff_addr[AW-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Load extraction from the registered RAM word using the latched lane info.
  always_comb begin
    ld_byte = ram_rdata[8*lo_q +: 8];
    ld_half = lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      SIZE_BYTE: ld_data = sign_q ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      SIZE_HALF: ld_data = sign_q ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default:   ld_data = ram_rdata;
    endcase
  end

  assign rsp_valid = rsp_q & ~kill;
  assign exc_valid = exc_q & ~kill;
  assign rsp_rdata = (state == ST_DEV_RSP)          ? dev_rdata_q :
                     ((state == ST_DM_RSP) && ld_q) ? ld_data     : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rsp_q        <= 1'b0;
      exc_q        <= 1'b0;
      ld_q         <= 1'b0;
      sign_q       <= 1'b0;
      lo_q         <= 2'b00;
      size_q       <= 2'b00;
      exc_code     <= 5'd0;
      exc_pc       <= 32'b0;
      exc_badvaddr <= 32'b0;
      dev_req      <= 1'b0;
      dev_we       <= 1'b0;
      dev_addr     <= 32'b0;
      dev_wdata    <= 32'b0;
      dev_rdata_q  <= 32'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DM_RSP: begin
          state        <= ST_IDLE;
          rsp_q        <= 1'b0;
          exc_q        <= 1'b0;
          ld_q         <= 1'b0;
          exc_code     <= 5'd0;
          exc_pc       <= 32'b0;
          exc_badvaddr <= 32'b0;
          if (accept) begin
            if (!fault && dev_hit) begin
              state     <= ST_DEV_WAIT;
              dev_req   <= 1'b1;
              dev_we    <= req_we;
              dev_addr  <= {eff_addr[31:2], 2'b00};
              dev_wdata <= req_wdata;
            end else begin
              state <= ST_DM_RSP;
              if (fault) begin
                exc_q        <= 1'b1;
                exc_code     <= req_we ? EXC_ADES : EXC_ADEL;
                exc_pc       <= req_pc;
                exc_badvaddr <= req_addr;
              end else begin
                // Unmapped (feature off) still acks; ld_q=0 forces data 0.
                rsp_q  <= 1'b1;
                ld_q   <= dm_hit & ~req_we;
                lo_q   <= eff_addr[1:0];
                size_q <= size_n;
                sign_q <= req_sign;
              end
            end
          end
        end
        ST_DEV_WAIT: begin
          if (dev_ack) begin
            dev_req   <= 1'b0;
            dev_we    <= 1'b0;
            dev_addr  <= 32'b0;
            dev_wdata <= 32'b0;
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              state       <= ST_DEV_RSP;
              rsp_q       <= 1'b1;
              dev_rdata_q <= dev_we ? 32'b0 : dev_rdata;
            end
          end else if (flush) begin
            state <= ST_DEV_DRAIN;
          end
        end
        ST_DEV_DRAIN: begin
          // Keep the strobe up so the device transfer completes cleanly.
          if (dev_ack) begin
            state     <= ST_IDLE;
            dev_req   <= 1'b0;
            dev_we    <= 1'b0;
            dev_addr  <= 32'b0;
            dev_wdata <= 32'b0;
          end
        end
        ST_DEV_RSP: begin
          state       <= ST_IDLE;
          rsp_q       <= 1'b0;
          dev_rdata_q <= 32'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
